byte_data_memory: RTL

Parametrised, byte-addressable RV32 data memory with load/store size control, sign/zero extension, misalignment flagging and a hardware clear sequence after reset. It sits in the MEM stage of the rv32 single-cycle core and succeeds the word-only data memory. It serves LB/LH/LW/LBU/LHU and SB/SH/SW through a valid/ready request port and returns a registered response one cycle later.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_load_extend.sv | 23 ++
 rtl/byte_data_memory.sv | 106 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressable RV32 data memory.
package dmem_pkg;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10} mem_size_e;
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} dmem_state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_B:  lane_mask = 4'b0001 << offset;
      SIZE_H:  lane_mask = 4'b0011 << offset;
      SIZE_W:  lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = offset[0];
      SIZE_W:  misaligned = |offset;
      default: misaligned = 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/dmem_load_extend.sv
// Picks the addressed byte/half out of a stored word and sign/zero-extends it.
module dmem_load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = word[{offset[1], 4'b0000} +: 16];
    case (size)
      SIZE_B:  ext = {{24{~is_unsigned & b[7]}}, b};
      SIZE_H:  ext = {{16{~is_unsigned & h[15]}}, h};
      default: ext = word;
    endcase
  end
endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable RV32 data memory: clear-after-reset, valid/ready requests,
// one-cycle registered response with extension and misalignment flag.
module byte_data_memory
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] INIT_VALUE = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] data_read_o,
  output logic                  misaligned_o
);
  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  generate
    if (DATA_WIDTH != 32) begin : g_width_chk
      $error("byte_data_memory: DATA_WIDTH must be 32");
    end
  endgenerate

  logic [3:0][7:0] mem [DEPTH];
  dmem_state_e     state;
  logic [IW-1:0]   clr_cnt;

  logic            accept, fault;
  logic [IW-1:0]   idx;
  logic [1:0]      off;
  logic [3:0]      mask;
  logic [31:0]     wrep, rd_word, ld_ext;

  assign accept  = req_valid_i & req_ready_o;
  assign idx     = address_i[ADDR_WIDTH-1:2];
  assign off     = address_i[1:0];
  assign fault   = misaligned(req_size_i, off);
  assign mask    = lane_mask(req_size_i, off);
  assign rd_word = mem[idx];

  // Replicate right-aligned store data so every lane sees its byte.
  generate
    for (genvar l = 0; l < 4; l++) begin : g_lane
      always_comb begin
        case (req_size_i)
          SIZE_B:  wrep[l*8 +: 8] = write_data_i[7:0];
          SIZE_H:  wrep[l*8 +: 8] = write_data_i[(l%2)*8 +: 8];
          default: wrep[l*8 +: 8] = write_data_i[l*8 +: 8];
        endcase
      end
    end
  endgenerate

  dmem_load_extend u_ext (
    .word        (rd_word),
    .offset      (off),
    .size        (req_size_i),
    .is_unsigned (req_unsigned_i),
    .ext         (ld_ext)
  );

  // Storage has no reset; the CLEAR walk initialises it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= INIT_VALUE;
    end else if (accept && req_write_i && !fault) begin
      for (int l = 0; l < 4; l++)
        if (mask[l]) mem[idx][l] <= wrep[l*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      req_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      data_read_o  <= '0;
      misaligned_o <= 1'b0;
    end else begin
      rsp_valid_o <= accept;
      if (accept) begin
        misaligned_o <= fault;
        data_read_o  <= (fault || req_write_i) ? '0 : ld_ext;
      end
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == IW'(DEPTH - 1)) begin
            state       <= READY;
            req_ready_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
